// File: rtl/match_collector_pkg.sv
// Shared definitions for the match collector: write-port FSM states and word geometry.
package match_collector_pkg;

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_TRAILER = 2'd2
    } wr_state_e;

    function automatic int ids_per_word(input int out_w, input int id_w);
        return out_w / id_w;
    endfunction

endpackage

// File: rtl/match_collector_result_fifo.sv
// Synchronous first-word-fall-through FIFO: RAM with registered read feeding an output holding register.
module match_collector_result_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, ram_cnt;
    logic             out_vld_q;
    logic [WIDTH-1:0] out_q;
    logic             push, pop, load;

    // cnt_q counts the holding register too, so "full" means DEPTH words in total
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign push    = push_i && !full_o;
    assign pop     = out_vld_q && pop_i;
    assign ram_cnt = cnt_q - (AW+1)'(out_vld_q);
    assign load    = (ram_cnt != '0) && (!out_vld_q || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (load) begin
                out_q  <= mem[rptr_q];
                rptr_q <= rptr_q + 1'b1;
            end
            if (load)     out_vld_q <= 1'b1;
            else if (pop) out_vld_q <= 1'b0;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rdata_o = out_q;
    assign valid_o = out_vld_q;

endmodule

// File: rtl/match_collector.sv
// Packs matching vector IDs into wide words, appends flush/trailer words per frame, buffers in a FIFO.
// state      | meaning
// ST_ACC     | packing only; FIFO write port serves data words
// ST_FLUSH   | padded partial word of the finished frame waits for the write port
// ST_TRAILER | match-count trailer (last) waits for the write port
module match_collector
    import match_collector_pkg::*;
#(
    parameter int VEC_ID_WIDTH = 16,
    parameter int OUT_WIDTH    = 512,
    parameter int FIFO_DEPTH   = 512,
    parameter int MCNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [VEC_ID_WIDTH-1:0] i_ID,
    input  logic                    i_Match,
    input  logic                    i_Valid,
    input  logic                    i_Last,
    output logic [OUT_WIDTH-1:0]    o_TData,
    output logic                    o_TValid,
    input  logic                    i_TReady,
    output logic                    o_TLast,
    output logic                    o_Overflow
);
    localparam int IPW = ids_per_word(OUT_WIDTH, VEC_ID_WIDTH);
    localparam int SW  = $clog2(IPW);
    localparam logic [VEC_ID_WIDTH-1:0] SENTINEL = '1;
    localparam logic [SW-1:0]           SLOT_MAX = SW'(IPW - 1);

    logic [SW-1:0]         slot_q, slot_d;
    logic [SW:0]           fill;
    logic [OUT_WIDTH-1:0]  pack_q, pack_d, data_q, flush_q, flush_d, trailer_q, trailer_d;
    logic                  data_vld_q;
    logic [MCNT_WIDTH-1:0] mcnt_q, mcnt_new, mcnt_d;
    logic                  beat_match, frame_end, word_done, flush_exists;
    wr_state_e             state_q, state_d;
    logic                  stall_q, stall_d, drop, lost;
    logic                  wr_en, wr_last, fifo_full;
    logic [OUT_WIDTH-1:0]  wr_data;
    logic                  ovf_q;

    assign beat_match   = i_Valid && i_Match;
    assign frame_end    = i_Valid && i_Last;
    assign word_done    = beat_match && (slot_q == SLOT_MAX);
    assign fill         = {1'b0, slot_q} + (SW+1)'(beat_match);
    assign flush_exists = (fill != '0) && !word_done;

    always_comb begin
        pack_d = pack_q;
        if (beat_match) pack_d[slot_q*VEC_ID_WIDTH +: VEC_ID_WIDTH] = i_ID;
        flush_d = '1;
        for (int j = 0; j < IPW; j++)
            flush_d[j*VEC_ID_WIDTH +: VEC_ID_WIDTH] =
                (j < int'(fill)) ? pack_d[j*VEC_ID_WIDTH +: VEC_ID_WIDTH] : SENTINEL;
        mcnt_new  = mcnt_q + MCNT_WIDTH'(beat_match && (mcnt_q != '1));
        mcnt_d    = frame_end ? '0 : mcnt_new;
        trailer_d = '1;
        trailer_d[MCNT_WIDTH-1:0] = mcnt_new;
        if (frame_end || word_done) slot_d = '0;
        else if (beat_match)        slot_d = slot_q + 1'b1;
        else                        slot_d = slot_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_q     <= '0;
            pack_q     <= '0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            flush_q    <= '0;
            trailer_q  <= '0;
            mcnt_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            pack_q     <= pack_d;
            mcnt_q     <= mcnt_d;
            data_vld_q <= word_done;
            if (word_done) data_q <= pack_d;
            if (frame_end) begin
                flush_q   <= flush_d;
                trailer_q <= trailer_d;
            end
            ovf_q <= ovf_q | drop | lost | (wr_en && fifo_full);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_ACC;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // A data word owns the write port; a held flush/trailer gets one retry before it is discarded
    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        drop    = 1'b0;
        lost    = 1'b0;
        case (state_q)
            ST_FLUSH, ST_TRAILER: begin
                if (data_vld_q && !stall_q) begin
                    stall_d = 1'b1;
                end else begin
                    drop    = data_vld_q;
                    state_d = (state_q == ST_FLUSH) ? ST_TRAILER : ST_ACC;
                end
            end
            default: state_d = state_q;
        endcase
        if (frame_end) begin
            lost    = (state_q == ST_FLUSH) ||
                      ((state_q == ST_TRAILER) && data_vld_q && !stall_q);
            state_d = flush_exists ? ST_FLUSH : ST_TRAILER;
            stall_d = 1'b0;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_data = data_q;
        if (data_vld_q) begin
            wr_en = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            wr_en   = 1'b1;
            wr_data = flush_q;
        end else if (state_q == ST_TRAILER) begin
            wr_en   = 1'b1;
            wr_last = 1'b1;
            wr_data = trailer_q;
        end
    end

    match_collector_result_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (wr_en),
        .wdata_i ({wr_last, wr_data}),
        .full_o  (fifo_full),
        .pop_i   (i_TReady),
        .rdata_o ({o_TLast, o_TData}),
        .valid_o (o_TValid)
    );

    assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_match_collector.sv
// Directed bench for match_collector with a frame-level model of the expected result stream.
module tb_match_collector;
    localparam int W     = 16;
    localparam int OW    = 512;
    localparam int DEPTH = 4;
    localparam int MW    = 32;
    localparam int IPW   = OW / W;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  i_ID;
    logic          i_Match, i_Valid, i_Last, i_TReady;
    logic [OW-1:0] o_TData;
    logic          o_TValid, o_TLast, o_Overflow;

    int tests = 0;
    int fails = 0;
    logic [OW:0] exp_q[$];
    logic [OW:0] rx_q[$];
    logic [OW:0] exp_w;

    always #5 clk = ~clk;

    match_collector #(
        .VEC_ID_WIDTH (W),
        .OUT_WIDTH    (OW),
        .FIFO_DEPTH   (DEPTH),
        .MCNT_WIDTH   (MW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_ID       (i_ID),
        .i_Match    (i_Match),
        .i_Valid    (i_Valid),
        .i_Last     (i_Last),
        .o_TData    (o_TData),
        .o_TValid   (o_TValid),
        .i_TReady   (i_TReady),
        .o_TLast    (o_TLast),
        .o_Overflow (o_Overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_match(input int i, input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return (i % 3) == 0;
    endfunction

    function automatic logic [63:0] slot_of(input logic [OW:0] w, input int j);
        return 64'(w[j*W +: W]);
    endfunction

    // Expected words of one frame: matched IDs in arrival order, chunked, padded with all-ones, then count trailer
    task automatic model_frame(input int n, input int base, input int mode);
        logic [W-1:0]  ids[$];
        logic [OW-1:0] wd;
        for (int i = 0; i < n; i++)
            if (is_match(i, mode)) ids.push_back(W'(base + i));
        for (int s = 0; s < ids.size(); s += IPW) begin
            wd = '1;
            for (int j = 0; j < IPW && s + j < ids.size(); j++) wd[j*W +: W] = ids[s+j];
            exp_q.push_back({1'b0, wd});
        end
        wd = '1;
        wd[MW-1:0] = MW'(ids.size());
        exp_q.push_back({1'b1, wd});
    endtask

    task automatic idle();
        i_Valid = 1'b0;
        i_Match = 1'b0;
        i_Last  = 1'b0;
        i_ID    = '0;
    endtask

    task automatic drive_frame(input int n, input int base, input int mode, input bit with_last);
        for (int i = 0; i < n; i++) begin
            i_Valid = 1'b1;
            i_ID    = W'(base + i);
            i_Match = is_match(i, mode);
            i_Last  = with_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rstn && o_TValid && i_TReady) begin
            rx_q.push_back({o_TLast, o_TData});
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL stream_extra: got %h expected no word", {o_TLast, o_TData});
            end else begin
                exp_w = exp_q.pop_front();
                if ({o_TLast, o_TData} !== exp_w) begin
                    fails++;
                    $display("FAIL stream_word: got %h expected %h", {o_TLast, o_TData}, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW:0] w;
        rstn = 1'b0;
        i_TReady = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(o_TValid), 64'd0);
        chk("rst_tlast", 64'(o_TLast), 64'd0);
        chk("rst_tdata", 64'(o_TData[63:0]), 64'd0);
        chk("rst_ovf", 64'(o_Overflow), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 70 all-match beats: two data words, flush of 64..69, trailer 70
        rx_q.delete();
        model_frame(70, 0, 1);
        drive_frame(70, 0, 1, 1'b1);
        idle();
        wait_drain("t1_drain", 200);
        chk("t1_words", 64'(rx_q.size()), 64'd4);
        w = rx_q[0];
        chk("t1_w0_s0", slot_of(w, 0), 64'd0);
        chk("t1_w0_s31", slot_of(w, 31), 64'd31);
        w = rx_q[1];
        chk("t1_w1_s0", slot_of(w, 0), 64'd32);
        w = rx_q[2];
        chk("t1_flush_s5", slot_of(w, 5), 64'd69);
        chk("t1_flush_s6", slot_of(w, 6), 64'hFFFF);
        chk("t1_flush_last", 64'(w[OW]), 64'd0);
        w = rx_q[3];
        chk("t1_trl_cnt", 64'(w[31:0]), 64'd70);
        chk("t1_trl_upper", 64'(w[OW-1:OW-32]), 64'hFFFF_FFFF);
        chk("t1_trl_last", 64'(w[OW]), 64'd1);

        // 100 beats, nothing matches: trailer only
        rx_q.delete();
        model_frame(100, 100, 0);
        drive_frame(100, 100, 0, 1'b1);
        idle();
        wait_drain("t2_drain", 200);
        chk("t2_words", 64'(rx_q.size()), 64'd1);
        w = rx_q[0];
        chk("t2_trl_cnt", 64'(w[31:0]), 64'd0);
        chk("t2_trl_last", 64'(w[OW]), 64'd1);

        // 64 all-match beats: last beat fills the final slot, no flush
        rx_q.delete();
        model_frame(64, 200, 1);
        drive_frame(64, 200, 1, 1'b1);
        idle();
        wait_drain("t3_drain", 200);
        chk("t3_words", 64'(rx_q.size()), 64'd3);
        w = rx_q[1];
        chk("t3_w1_s31", slot_of(w, 31), 64'd263);
        w = rx_q[2];
        chk("t3_trl_cnt", 64'(w[31:0]), 64'd64);

        // every third beat matches: 17 sparse IDs in one flush word
        rx_q.delete();
        model_frame(50, 300, 2);
        drive_frame(50, 300, 2, 1'b1);
        idle();
        wait_drain("t3b_drain", 200);
        chk("t3b_words", 64'(rx_q.size()), 64'd2);
        w = rx_q[0];
        chk("t3b_s16", slot_of(w, 16), 64'd348);
        chk("t3b_s17", slot_of(w, 17), 64'hFFFF);

        // two back-to-back 40-beat frames, i_Valid never drops
        rx_q.delete();
        model_frame(40, 400, 1);
        model_frame(40, 1000, 1);
        drive_frame(40, 400, 1, 1'b1);
        drive_frame(40, 1000, 1, 1'b1);
        idle();
        wait_drain("t4_drain", 300);
        chk("t4_words", 64'(rx_q.size()), 64'd6);
        w = rx_q[3];
        chk("t4_f2_s0", slot_of(w, 0), 64'd1000);
        chk("t4_ovf", 64'(o_Overflow), 64'd0);

        // downstream stalled: only DEPTH words survive, overflow sticks
        rx_q.delete();
        i_TReady = 1'b0;
        model_frame(200, 0, 1);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        drive_frame(200, 0, 1, 1'b1);
        idle();
        repeat (10) @(posedge clk);
        #1;
        chk("t5_ovf", 64'(o_Overflow), 64'd1);
        chk("t5_tvalid", 64'(o_TValid), 64'd1);
        chk("t5_head_s0", 64'(o_TData[W-1:0]), 64'd0);
        i_TReady = 1'b1;
        wait_drain("t5_drain", 100);
        chk("t5_words", 64'(rx_q.size()), 64'd4);
        w = rx_q[3];
        chk("t5_w3_s0", slot_of(w, 0), 64'd96);

        // reset mid-frame after 10 matches, then a 5-match frame
        rx_q.delete();
        drive_frame(10, 500, 1, 1'b0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
        chk("t6_rst_tvalid", 64'(o_TValid), 64'd0);
        chk("t6_rst_ovf", 64'(o_Overflow), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        model_frame(5, 600, 1);
        drive_frame(5, 600, 1, 1'b1);
        idle();
        wait_drain("t6_drain", 100);
        chk("t6_words", 64'(rx_q.size()), 64'd2);
        w = rx_q[0];
        chk("t6_flush_s4", slot_of(w, 4), 64'd604);
        chk("t6_flush_s5", slot_of(w, 5), 64'hFFFF);
        w = rx_q[1];
        chk("t6_trl_cnt", 64'(w[31:0]), 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
